// File: rtl/pipe_cla_addsub.sv
// pipe_cla_addsub: two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Optional zero/ovf result flags are built when PIPE_CLA_FLAGS_EN is defined.

module cla_slice #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  localparam int NG = N / 4;

  logic [NG:0] gc;
  assign gc[0] = cin;

  // Full lookahead inside each 4-bit group; group carries ripple group to group.
  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      assign g    = a[4*gi +: 4] & b[4*gi +: 4];
      assign p    = a[4*gi +: 4] ^ b[4*gi +: 4];
      assign c[0] = gc[gi];
      assign c[1] = g[0] | (p[0] & c[0]);
      assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & c[0]);
      assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]) | (&p & c[0]);
      assign s[4*gi +: 4] = p ^ c[3:0];
      assign gc[gi+1]     = c[4];
    end
  endgenerate

  assign cout = gc[NG];
endmodule

module pipe_cla_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef PIPE_CLA_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);
  localparam int H = WIDTH / 2;

  logic [WIDTH-1:0] b_eff;
  logic [H-1:0]     lo_sum;
  logic             lo_cout;
  logic [H-1:0]     hi_sum;
  logic             hi_cout;

  logic             s1_valid_reg;
  logic [H-1:0]     s1_lo_sum_reg;
  logic             s1_lo_cout_reg;
  logic [H-1:0]     s1_a_hi_reg;
  logic [H-1:0]     s1_b_hi_reg;

  logic             out_valid_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;

  logic             adv2;
  logic             adv1;

  // Subtract as A + ~B + 1: invert B here, the +1 enters as carry-in of bit 0.
  assign b_eff = sub ? ~b : b;

  assign adv2     = ~out_valid_reg | out_ready;
  assign adv1     = ~s1_valid_reg | adv2;
  assign in_ready = adv1;

  cla_slice #(.N(H)) u_lo (
    .a    (a[H-1:0]),
    .b    (b_eff[H-1:0]),
    .cin  (sub),
    .s    (lo_sum),
    .cout (lo_cout)
  );

  cla_slice #(.N(H)) u_hi (
    .a    (s1_a_hi_reg),
    .b    (s1_b_hi_reg),
    .cin  (s1_lo_cout_reg),
    .s    (hi_sum),
    .cout (hi_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      s1_lo_sum_reg  <= '0;
      s1_lo_cout_reg <= 1'b0;
      s1_a_hi_reg    <= '0;
      s1_b_hi_reg    <= '0;
    end else if (adv1) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_lo_sum_reg  <= lo_sum;
        s1_lo_cout_reg <= lo_cout;
        s1_a_hi_reg    <= a[WIDTH-1:H];
        s1_b_hi_reg    <= b_eff[WIDTH-1:H];
      end
    end
  end

  // Result registers only change when a new result moves in, so a stalled output holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
    end else if (adv2) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        sum_reg   <= {hi_sum, s1_lo_sum_reg};
        carry_reg <= hi_cout;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign carry     = carry_reg;

`ifdef PIPE_CLA_FLAGS_EN
  logic s1_sub_reg;
  logic zero_reg;
  logic ovf_reg;
  logic a_msb;
  logic b_msb;
  logic s_msb;
  logic ovf_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sub_reg <= 1'b0;
    end else if (adv1 && in_valid) begin
      s1_sub_reg <= sub;
    end
  end

  // Overflow: add overflows when same-sign operands give a differently signed result,
  // subtract when opposite-sign operands do.
  assign a_msb    = s1_a_hi_reg[H-1];
  assign b_msb    = s1_b_hi_reg[H-1] ^ s1_sub_reg;
  assign s_msb    = hi_sum[H-1];
  assign ovf_next = (a_msb ^ s_msb) & (s1_sub_reg ? (a_msb ^ b_msb) : ~(a_msb ^ b_msb));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (adv2 && s1_valid_reg) begin
      zero_reg <= ({hi_sum, s1_lo_sum_reg} == '0);
      ovf_reg  <= ovf_next;
    end
  end

  assign zero = zero_reg;
  assign ovf  = ovf_reg;
`endif
endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Self-checking bench for pipe_cla_addsub (WIDTH=16): directed cases, backpressure, reset and
// random traffic against an arithmetic reference queue. Flag checks follow PIPE_CLA_FLAGS_EN.
module tb_pipe_cla_addsub;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry;
`ifdef PIPE_CLA_FLAGS_EN
  logic         zero;
  logic         ovf;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_del    = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         z;
    logic         v;
  } res_t;

  res_t q[$];

  always #5 clk = ~clk;

  pipe_cla_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry)
`ifdef PIPE_CLA_FLAGS_EN
    ,
    .zero      (zero),
    .ovf       (ovf)
`endif
  );

  // Reference: plain unsigned arithmetic for sum/carry, signed integer range for overflow.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    res_t   r;
    logic [W:0] u;
    longint sx, sy, sr, hi, lo;
    u  = s ? ({1'b0, x} + {1'b0, ~y} + (W+1)'(1)) : ({1'b0, x} + {1'b0, y});
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sr = s ? (sx - sy) : (sx + sy);
    hi = (longint'(1) <<< (W-1)) - 1;
    lo = -(longint'(1) <<< (W-1));
    r.s = u[W-1:0];
    r.c = u[W];
    r.z = (u[W-1:0] == '0);
    r.v = (sr > hi) || (sr < lo);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input res_t e);
    check({tag, "_sum"}, 64'(sum), 64'(e.s));
    check({tag, "_carry"}, 64'(carry), 64'(e.c));
`ifdef PIPE_CLA_FLAGS_EN
    check({tag, "_zero"}, 64'(zero), 64'(e.z));
    check({tag, "_ovf"}, 64'(ovf), 64'(e.v));
`endif
  endtask

  // One cycle: drive at the falling edge, sample 1 time unit later, score what the next
  // rising edge will transfer.
  task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic is, input logic ordy, output logic acc);
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    sub       = is;
    out_ready = ordy;
    #1;
    if (q.size() == 0) begin
      check("idle_out_valid", 64'(out_valid), 64'(0));
    end else if (out_valid) begin
      check_result("front", q[0]);
      if (ordy) begin
        void'(q.pop_front());
        n_del++;
      end
    end
    acc = iv & in_ready;
    if (acc) begin
      q.push_back(model(ia, ib, is));
      n_acc++;
    end
    if (acc || (out_valid && ordy)) check("inflight_le2", 64'(q.size() <= 2), 64'(1));
  endtask

  // Single operation with out_ready high: result must appear exactly two cycles after accept.
  task automatic single(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                        input logic [W-1:0] exp_sum);
    logic acc;
    step(1'b1, ia, ib, is, 1'b1, acc);
    check("single_accept", 64'(acc), 64'(1));
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    check("single_lat1_out_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("single_lat2_out_valid", 64'(out_valid), 64'(1));
    check("single_const_sum", 64'(sum), 64'(exp_sum));
    check_result("single", q[0]);
    void'(q.pop_front());
    n_del++;
    $display("single a=%h b=%h sub=%0d -> sum=%h carry=%0d", ia, ib, is, sum, carry);
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
  endtask

  initial begin
    logic acc;
    int   k;
    int   cyc;
    logic [W-1:0] va[4];
    logic [W-1:0] vb[4];
    logic         vs[4];

    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_carry", 64'(carry), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
`ifdef PIPE_CLA_FLAGS_EN
    check("rst_zero", 64'(zero), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    $display("reset released");

    // Directed arithmetic cases
    single(16'h1234, 16'h0FFF, 1'b0, 16'h2233);
    single(16'hFFFF, 16'h0001, 1'b0, 16'h0000);
    single(16'h0005, 16'h0007, 1'b1, 16'hFFFE);
    single(16'h7FFF, 16'h0001, 1'b0, 16'h8000);
    single(16'h8000, 16'h0001, 1'b1, 16'h7FFF);
    single(16'h00FF, 16'h0001, 1'b0, 16'h0100);
    single(16'h4321, 16'h4321, 1'b1, 16'h0000);

    // Backpressure: four back-to-back inputs with the output stalled
    for (int i = 0; i < 4; i++) begin
      va[i] = W'($urandom);
      vb[i] = W'($urandom);
      vs[i] = 1'($urandom);
    end
    k = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, va[k], vb[k], vs[k], 1'b0, acc);
      if (c < 2) check("bp_accept_early", 64'(acc), 64'(1));
      else       check("bp_in_ready_low", 64'(in_ready), 64'(0));
      if (acc) k++;
      $display("stall cycle %0d in_ready=%0d out_valid=%0d sum=%h", c, in_ready, out_valid, sum);
    end
    check("bp_out_valid_held", 64'(out_valid), 64'(1));
    for (int c = 0; c < 4; c++) begin
      step(k < 4, va[k % 4], vb[k % 4], vs[k % 4], 1'b1, acc);
      check("bp_deliver_out_valid", 64'(out_valid), 64'(1));
      if (k < 4) check("bp_accept_on_consume", 64'(acc), 64'(1));
      if (acc) k++;
      $display("drain cycle %0d sum=%h carry=%0d", c, sum, carry);
    end
    check("bp_all_delivered", 64'(q.size()), 64'(0));

    // Reset mid-operation with two results in flight
    step(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0, acc);
    step(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b0, 1'b0, acc);
    check("mid_two_inflight", 64'(q.size()), 64'(2));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset pulsed with two in flight");
    for (int c = 0; c < 4; c++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, acc);
      check("mid_no_stale", 64'(out_valid), 64'(0));
    end
    single(16'h0F0F, 16'h0101, 1'b0, 16'h1010);

    // Random traffic
    n_acc = 0;
    n_del = 0;
    cyc   = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      step($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), 1'($urandom),
           $urandom_range(0, 3) != 0, acc);
      cyc++;
    end
    check("rand_budget", 64'(n_acc), 64'(10000));
    for (int c = 0; c < 10 && q.size() != 0; c++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    end
    check("rand_drained", 64'(q.size()), 64'(0));
    check("rand_conserved", 64'(n_del), 64'(n_acc));
    $display("random: %0d accepted, %0d delivered in %0d cycles", n_acc, n_del, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_cla_addsub.md
PIPE_CLA_ADDSUB -- requirements
Module: pipe_cla_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; legal values are multiples of 8 from 8 to 64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand set a/b/sub present.
REQ-005 SHALL have port in_ready  output  1  block accepts an operand set this cycle.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port sub  input  1  0 = A+B, 1 = A-B.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  downstream consumes the result.
REQ-011 SHALL have port sum  output  WIDTH  result.
REQ-012 SHALL have port carry  output  1  raw carry-out of MSB; in subtract mode, 1 = no borrow.

Function
REQ-013 SHALL implement subtraction as A + ~B + 1, with sub injected as carry-in of bit 0.
REQ-014 SHALL build every adder slice from 4-bit carry-lookahead groups: generate = a&b, propagate = a^b, lookahead carries inside each group, group carry rippled between groups.
REQ-015 SHALL split the datapath into 2 stages: stage 1 adds the low WIDTH/2 bits and registers low sum, low carry-out, upper a and ~b/b, and sub; stage 2 adds the upper WIDTH/2 bits using the registered carry.
REQ-016 SHALL accept an input on a cycle with in_valid & in_ready, and present the result with out_valid high exactly 2 cycles later when out_ready is held high.
REQ-017 SHALL advance stage 2 when out_valid is 0 or out_ready is 1, and SHALL advance stage 1 when stage 1 is empty or stage 2 advances.
REQ-018 SHALL drive in_ready = ~s1_valid | stage-2-advance, combinationally, with no dependence on in_valid.
REQ-019 SHALL sustain 1 result per cycle with out_ready held high.
REQ-020 SHALL hold sum, carry and the flags stable while out_valid=1 and out_ready=0.
REQ-021 SHALL NOT drop, duplicate or reorder results under any out_ready pattern; at most 2 results are in flight.
REQ-022 SHALL accept a new input on the same cycle a result is consumed when the pipeline is full.
REQ-023 SHALL propagate a carry correctly across the stage boundary, e.g. all-ones + 1 wraps to 0 with carry=1.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear both stage-valid bits, so out_valid=0, sum=0, carry=0 and all flags=0.
REQ-025 SHALL drive in_ready=1 during reset and on the first cycle after reset.
REQ-026 SHALL discard in-flight operations when reset is asserted mid-operation, and SHALL emit no stale result after release.

Configuration
REQ-027 SHALL add outputs zero (sum==0) and ovf (signed overflow of the selected operation) when macro PIPE_CLA_FLAGS_EN is defined, both registered with the result in stage 2 and both 0 at reset.
REQ-028 SHALL omit the zero and ovf ports and their logic when PIPE_CLA_FLAGS_EN is undefined; all other behaviour is unchanged.

Verification (WIDTH=16, PIPE_CLA_FLAGS_EN defined)
REQ-029 SHALL cover: a=0x1234, b=0x0FFF, sub=0, out_ready=1 -> 2 cycles later sum=0x2233, carry=0, zero=0, ovf=0.
REQ-030 SHALL cover: a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, carry=1, zero=1, ovf=0.
REQ-031 SHALL cover: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, carry=0; and a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1.
REQ-032 SHALL cover: 4 back-to-back inputs with out_ready=0 -> in_ready falls after 2 accepts and first result held; out_ready=1 -> 4 results delivered in order, 1 per cycle.
REQ-033 SHALL cover: 2 operations in flight, rst_n pulsed low mid-cycle -> out_valid=0 immediately, and no output until a new input is accepted.
REQ-034 SHALL cover: random operands and random in_valid/out_ready for 10,000 transactions, checked against a reference model -> sum/carry/ovf match and transaction count is conserved.
